seq_adder: RTL and testbench

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder.sv | 132 +++++++++++++
 tb/tb_seq_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over K = WIDTH/CHUNK cycles.
// Results are registered on entry to DONE and hold until the next operation completes.
module seq_adder #(
    parameter int WIDTH = 9,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             ovf
);

    localparam int K  = WIDTH / CHUNK;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK:0]   chunk_add;
    logic [WIDTH-1:0] acc_shift;
    logic             msb_cin;
    logic             last_chunk;
    logic             accept;

    // The accumulator fills from the top, so after K shifts it holds the full sum.
    always_comb begin
        chunk_add  = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        acc_shift  = WIDTH'({chunk_add[CHUNK-1:0], acc_q} >> CHUNK);
        msb_cin    = opa_q[CHUNK-1] ^ opb_q[CHUNK-1] ^ chunk_add[CHUNK-1];
        last_chunk = (cnt_q == CW'(K - 1));
        accept     = start && ((state_q == IDLE) || (state_q == DONE));
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                acc_d   = acc_shift;
                carry_d = chunk_add[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    state_d = DONE;
                    sum_d   = acc_shift;
                    cout_d  = chunk_add[CHUNK];
                    ovf_d   = msb_cin ^ chunk_add[CHUNK];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Subtraction is a + ~b + 1, so invert b and seed the carry with sub.
        if (accept) begin
            state_d = RUN;
            opa_d   = a;
            opb_d   = b ^ {WIDTH{sub}};
            carry_d = sub;
            cnt_d   = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cOut = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: directed vector table, multi-cycle corner
// sequences and a randomized sweep against an arithmetic reference model.
module tb_seq_adder;

    localparam int W  = 9;
    localparam int C  = 3;
    localparam int K  = W / C;
    localparam int W2 = 16;
    localparam int C2 = 4;
    localparam int K2 = W2 / C2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, sub;
    logic [W-1:0]  a, b, sum;
    logic          busy, done, cOut, ovf;
    logic          start16, sub16;
    logic [W2-1:0] a16, b16, sum16;
    logic          busy16, done16, cout16, ovf16;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cOut(cOut), .ovf(ovf)
    );

    seq_adder #(.WIDTH(W2), .CHUNK(C2)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cOut(cout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result modulo 2^w, signed range test for overflow.
    function automatic void ref_model(input int w, input longint x, input longint y, input bit s,
                                      output longint rs, output bit rc, output bit ro);
        longint m, full, sx, sy, r;
        m    = 64'sd1 << w;
        full = s ? (x - y + m) : (x + y);
        rs   = full % m;
        rc   = (full >= m);
        sx   = (x >= m / 2) ? x - m : x;
        sy   = (y >= m / 2) ? y - m : y;
        r    = s ? (sx - sy) : (sx + sy);
        ro   = (r >= m / 2) || (r < -(m / 2));
    endfunction

    task automatic apply_stimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        sub   = ts;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_output(input logic [W-1:0] es, input logic ec, input logic eo, input bit hold);
        for (int i = 0; i < K; i++) begin
            chk("busy_run", busy, 1'b1);
            chk("done_run", done, 1'b0);
            if (hold) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("sum", sum, es);
        chk("cOut", cOut, ec);
        chk("ovf", ovf, eo);
    endtask

    task automatic check_hold(input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        chk("done_idle", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("sum_hold", sum, es);
        chk("cOut_hold", cOut, ec);
        chk("ovf_hold", ovf, eo);
    endtask

    task automatic run16(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic s);
        longint es;
        bit     ec, eo;
        ref_model(W2, longint'(x), longint'(y), s, es, ec, eo);
        start16 = 1'b1;
        a16     = x;
        b16     = y;
        sub16   = s;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < K2; i++) begin
            chk("busy16_run", busy16, 1'b1);
            chk("done16_run", done16, 1'b0);
            @(negedge clk);
        end
        chk("done16_pulse", done16, 1'b1);
        chk("sum16", sum16, es);
        chk("cout16", cout16, ec);
        chk("ovf16", ovf16, eo);
        @(negedge clk);
    endtask

    initial begin
        longint es;
        bit     ec, eo;
        logic [W-1:0] ra, rb;
        int     base_done, accepted;

        vecs[0] = '{9'd200, 9'd100, 1'b0, 9'h12C, 1'b0, 1'b1};
        vecs[1] = '{9'd511, 9'd1,   1'b0, 9'h000, 1'b1, 1'b0};
        vecs[2] = '{9'd5,   9'd7,   1'b1, 9'h1FE, 1'b0, 1'b0};
        vecs[3] = '{9'd255, 9'd1,   1'b0, 9'h100, 1'b0, 1'b1};
        vecs[4] = '{9'd256, 9'd1,   1'b1, 9'h0FF, 1'b1, 1'b1};
        vecs[5] = '{9'd0,   9'd0,   1'b1, 9'h000, 1'b1, 1'b0};
        vecs[6] = '{9'd100, 9'd200, 1'b1, 9'h19C, 1'b0, 1'b0};
        vecs[7] = '{9'd511, 9'd511, 1'b0, 9'h1FE, 1'b1, 1'b0};

        reset = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_cOut", cOut, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // First start lands on the very first edge after release; operations chain back-to-back.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sub);
            check_output(vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 1'b0);
        end
        check_hold(vecs[7].exp_sum, vecs[7].exp_cout, vecs[7].exp_ovf);

        ref_model(W, 64'h0AA, 64'h0F0, 1'b0, es, ec, eo);
        apply_stimulus(9'h0AA, 9'h0F0, 1'b0);
        check_output(W'(es), ec, eo, 1'b1);

        apply_stimulus(9'd3, 9'd4, 1'b0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, '0);
        chk("abort_cOut", cOut, 1'b0);
        chk("abort_ovf", ovf, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2 * K; i++) begin
            @(negedge clk);
            chk("post_abort_done", done, 1'b0);
            chk("post_abort_busy", busy, 1'b0);
        end

        base_done = done_cnt;
        accepted  = 0;
        for (int mode = 0; mode < 2; mode++) begin
            for (int n = 0; n < 1000; n++) begin
                case ($urandom_range(0, 7))
                    0: ra = '0;
                    1: ra = '1;
                    2: ra = 9'h100;
                    default: ra = W'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0: rb = '0;
                    1: rb = '1;
                    2: rb = 9'h0FF;
                    default: rb = W'($urandom);
                endcase
                ref_model(W, longint'(ra), longint'(rb), mode[0], es, ec, eo);
                apply_stimulus(ra, rb, mode[0]);
                accepted++;
                check_output(W'(es), ec, eo, 1'b0);
                if ($urandom_range(0, 3) == 0) check_hold(W'(es), ec, eo);
            end
        end
        @(negedge clk);
        chk("done_pulse_count", done_cnt - base_done, accepted);

        run16(16'hFFFF, 16'h0001, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0);
        chk("sum16_7fff", sum16, 16'h8000);
        chk("ovf16_7fff", ovf16, 1'b1);
        for (int n = 0; n < 20; n++) run16(W2'($urandom), W2'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
